enqueue_agent_v1: RTL and testbench
===================================

// Module: enqueue_agent_v1
// PURPOSE
//  Parametrised successor of the v0.1 enqueue agent. Sits between the P4 pipeline output and the per-port packet buffers/PIFOs.
//  Decodes destination queues from SUME tuser on the first beat, then masks them against buffer-almost-full and PIFO-full status.
//  Writes every beat of the packet to the surviving buffers, then issues one PIFO descriptor (rank, length) per queue after tlast.
// PARAMETERS
//  NUM_PORTS   4    physical ports; queue count NQ = NUM_PORTS+1 (index NUM_PORTS = CPU queue)
//  TUSER_W     128  s_axis_tuser width
//  DST_POS     24   LSB of dst field; port i phys bit = DST_POS+2i, CPU bit = DST_POS+2i+1
//  DROP_POS    32   tuser bit forcing drop
//  RANK_POS    64   LSB of rank field in tuser
//  RANK_W      16   rank width
//  LEN_W       12   beat-count width of packet length
// PORTS
//  axis_aclk                 in   1          clock
//  axis_reset                in   1          async active-high reset
//  s_axis_tvalid             in   1          pipeline beat valid
//  s_axis_tready             out  1          agent ready
//  s_axis_tuser              in   TUSER_W    sume_meta (sampled on first beat only)
//  s_axis_tlast              in   1          last beat of packet
//  s_axis_buffer_almost_full in   NQ         per-queue buffer almost full
//  s_axis_pifo_full          in   NQ         per-queue PIFO full
//  m_axis_ctl_buffer_wr_en   out  NQ         per-queue buffer write strobe, aligned to beat
//  m_axis_ctl_pifo_in_en     out  NQ         per-queue PIFO insert pulse
//  m_axis_ctl_pifo_rank      out  RANK_W     rank carried with pifo_in_en
//  m_axis_ctl_pifo_len       out  LEN_W      packet length in beats carried with pifo_in_en
// BEHAVIOUR
//  Reset: state=IDLE; tready=0 while axis_reset high, 1 in the first cycle after release; all wr_en/in_en=0; rank/len/mask=0.
//  Beat accepted = tvalid & tready; tready is 1 in IDLE and PKT.
//  Request mask req[i] (i<NUM_PORTS) = tuser[DST_POS+2i].
//  req[NUM_PORTS] = OR over i of tuser[DST_POS+2i+1].
//  Enable mask en = req & ~buffer_almost_full & ~pifo_full, forced to 0 when tuser[DROP_POS]=1.
//  IDLE: accepted beat = SOP; en is computed combinationally; buffer_wr_en = en in the same cycle (zero latency).
//    en, rank and len=1 are latched. SOP with tlast stays in IDLE and schedules a descriptor; otherwise -> PKT.
//  PKT: each accepted beat drives buffer_wr_en = latched mask, and len increments, saturating at 2^LEN_W-1.
//    tuser and status inputs are ignored. Accepted tlast -> IDLE and schedules a descriptor.
//  Descriptor: the cycle after the tlast beat, pifo_in_en = latched mask (one-cycle pulse, registered).
//    rank and len are held valid with it. If the mask is 0, no pulse is issued (drop).
//  Status change mid-packet does not alter the mask: the decision is per packet.
//  Back-to-back: a new SOP in the descriptor cycle is legal; descriptor registers are separate from the latch.
//  Reset mid-packet returns to IDLE; the next accepted beat is treated as SOP (the partial packet is orphaned).
//  tvalid=0 inside a packet: hold state; no wr_en.
// CONFIGURATION
//  ENQ_AGENT_STATS_EN defined: per queue, 32-bit wrapping enq_cnt (+1 per pifo_in_en bit).
//    Also a 32-bit wrapping cong_drop_cnt, +1 at SOP when req[i]=1, en[i]=0 and drop bit is 0.
//    Extra ports: stat_sel in $clog2(NQ), stat_clr in 1 (sync clear all), stat_enq_cnt out 32, stat_drop_cnt out 32 (registered, 1-cycle read latency).
//  Undefined: counters and ports absent; datapath identical.
// TESTING
//  1 SOP dst port0+port3, buffer_af=5'b01110, 2 beats -> wr_en=5'b00001 on both beats; in_en=5'b00001 next cycle, len=2.
//  2 dst ports 1,2,3, no full, 3 beats, rank=16'h00A5 -> wr_en=5'b01110 x3, in_en=5'b01110, rank=16'h00A5, len=3.
//  3 dst 1,2,3, pifo_full=5'b01110 -> wr_en=0, in_en=0; with STATS, drop cnt q1..q3 = 1.
//  4 dst bits DST_POS+1 and DST_POS+3 (CPU from ports 0,1) -> en=5'b10000. Drop bit set with dst 0,1,2 -> all zero. pifo_full toggled mid-packet -> mask unchanged.
//  5 single-beat packet followed by SOP next cycle -> two in_en pulses, both len=1. Reset asserted in PKT -> all outputs 0, next beat SOP.

Source files
------------

// File: rtl/enqueue_agent_v1.sv
// enqueue_agent_v1: steers P4 pipeline beats into per-queue packet buffers
// and issues one PIFO descriptor (rank, length) per destination queue after
// each packet. The queue mask is decided once per packet at SOP.
// Optional per-queue enqueue/congestion-drop counters: ENQ_AGENT_STATS_EN.
module enqueue_agent_v1 #(
  parameter int NUM_PORTS = 4,
  parameter int TUSER_W   = 128,
  parameter int DST_POS   = 24,
  parameter int DROP_POS  = 32,
  parameter int RANK_POS  = 64,
  parameter int RANK_W    = 16,
  parameter int LEN_W     = 12
) (
  input  logic                   axis_aclk,
  input  logic                   axis_reset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TUSER_W-1:0]     s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic [NUM_PORTS:0]     s_axis_buffer_almost_full,
  input  logic [NUM_PORTS:0]     s_axis_pifo_full,
  output logic [NUM_PORTS:0]     m_axis_ctl_buffer_wr_en,
  output logic [NUM_PORTS:0]     m_axis_ctl_pifo_in_en,
  output logic [RANK_W-1:0]      m_axis_ctl_pifo_rank,
  output logic [LEN_W-1:0]       m_axis_ctl_pifo_len
`ifdef ENQ_AGENT_STATS_EN
  ,
  input  logic [$clog2(NUM_PORTS+1)-1:0] stat_sel,
  input  logic                   stat_clr,
  output logic [31:0]            stat_enq_cnt,
  output logic [31:0]            stat_drop_cnt
`endif
);

  localparam int NQ = NUM_PORTS + 1;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t            state_q, state_d;
  logic [NQ-1:0]     mask_q, mask_d;
  logic [RANK_W-1:0] rank_q, rank_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NQ-1:0]     desc_en_q, desc_en_d;
  logic [RANK_W-1:0] desc_rank_q, desc_rank_d;
  logic [LEN_W-1:0]  desc_len_q, desc_len_d;

  logic              accept;
  logic              drop_bit;
  logic [NQ-1:0]     req;
  logic [NQ-1:0]     en;
  logic              unused_tuser;

  // Beat-count increment that sticks at the largest representable length
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Only the dst, drop and rank fields of tuser are consumed
  assign unused_tuser = ^s_axis_tuser;

  // Ready is gated only by reset: the agent never backpressures a packet
  assign s_axis_tready = ~axis_reset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign drop_bit      = s_axis_tuser[DROP_POS];

  // Decode destination queues and mask them against congestion status
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i]         = s_axis_tuser[DST_POS + 2*i];
      req[NUM_PORTS] = req[NUM_PORTS] | s_axis_tuser[DST_POS + 2*i + 1];
    end
    en = drop_bit ? '0 : (req & ~s_axis_buffer_almost_full & ~s_axis_pifo_full);
  end

  // Packet FSM: latch the per-packet decision at SOP, count beats, schedule descriptor
  always_comb begin
    state_d                 = state_q;
    mask_d                  = mask_q;
    rank_d                  = rank_q;
    len_d                   = len_q;
    desc_en_d               = '0;
    desc_rank_d             = desc_rank_q;
    desc_len_d              = desc_len_q;
    m_axis_ctl_buffer_wr_en = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          m_axis_ctl_buffer_wr_en = en;
          mask_d = en;
          rank_d = s_axis_tuser[RANK_POS +: RANK_W];
          len_d  = LEN_W'(1);
          if (s_axis_tlast) begin
            desc_en_d   = en;
            desc_rank_d = s_axis_tuser[RANK_POS +: RANK_W];
            desc_len_d  = LEN_W'(1);
          end else begin
            state_d = S_PKT;
          end
        end
      end
      S_PKT: begin
        if (accept) begin
          m_axis_ctl_buffer_wr_en = mask_q;
          len_d = sat_inc(len_q);
          if (s_axis_tlast) begin
            desc_en_d   = mask_q;
            desc_rank_d = rank_q;
            desc_len_d  = sat_inc(len_q);
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, packet latch and descriptor registers
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      rank_q      <= '0;
      len_q       <= '0;
      desc_en_q   <= '0;
      desc_rank_q <= '0;
      desc_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      rank_q      <= rank_d;
      len_q       <= len_d;
      desc_en_q   <= desc_en_d;
      desc_rank_q <= desc_rank_d;
      desc_len_q  <= desc_len_d;
    end
  end

  assign m_axis_ctl_pifo_in_en = desc_en_q;
  assign m_axis_ctl_pifo_rank  = desc_rank_q;
  assign m_axis_ctl_pifo_len   = desc_len_q;

`ifdef ENQ_AGENT_STATS_EN
  logic [31:0] enq_cnt_q  [NQ];
  logic [31:0] enq_cnt_d  [NQ];
  logic [31:0] drop_cnt_q [NQ];
  logic [31:0] drop_cnt_d [NQ];
  logic [31:0] stat_enq_q, stat_enq_d;
  logic [31:0] stat_drop_q, stat_drop_d;
  logic        sop;

  assign sop = accept & (state_q == S_IDLE);

  // Count descriptor pulses and congestion drops per queue; registered readback
  always_comb begin
    enq_cnt_d   = enq_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    stat_enq_d  = '0;
    stat_drop_d = '0;
    if (stat_clr) begin
      for (int i = 0; i < NQ; i++) begin
        enq_cnt_d[i]  = '0;
        drop_cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (desc_en_q[i])
          enq_cnt_d[i] = enq_cnt_q[i] + 32'd1;
        if (sop && req[i] && !en[i] && !drop_bit)
          drop_cnt_d[i] = drop_cnt_q[i] + 32'd1;
      end
    end
    if (int'(stat_sel) < NQ) begin
      stat_enq_d  = enq_cnt_q[stat_sel];
      stat_drop_d = drop_cnt_q[stat_sel];
    end
  end

  // Statistics registers
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      for (int i = 0; i < NQ; i++) begin
        enq_cnt_q[i]  <= '0;
        drop_cnt_q[i] <= '0;
      end
      stat_enq_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      enq_cnt_q   <= enq_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      stat_enq_q  <= stat_enq_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_enq_cnt  = stat_enq_q;
  assign stat_drop_cnt = stat_drop_q;
`endif

endmodule

// File: tb/tb_enqueue_agent_v1.sv
// Directed bench for enqueue_agent_v1 (default parameters, NQ = 5).
module tb_enqueue_agent_v1;

  logic         clk = 1'b0;
  logic         rst;
  logic         tvalid;
  logic         tready;
  logic [127:0] tuser;
  logic         tlast;
  logic [4:0]   baf;
  logic [4:0]   pfull;
  logic [4:0]   wr_en;
  logic [4:0]   in_en;
  logic [15:0]  rank;
  logic [11:0]  len;
`ifdef ENQ_AGENT_STATS_EN
  logic [2:0]   stat_sel;
  logic         stat_clr;
  logic [31:0]  stat_enq_cnt;
  logic [31:0]  stat_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enqueue_agent_v1 dut (
    .axis_aclk                 (clk),
    .axis_reset                (rst),
    .s_axis_tvalid             (tvalid),
    .s_axis_tready             (tready),
    .s_axis_tuser              (tuser),
    .s_axis_tlast              (tlast),
    .s_axis_buffer_almost_full (baf),
    .s_axis_pifo_full          (pfull),
    .m_axis_ctl_buffer_wr_en   (wr_en),
    .m_axis_ctl_pifo_in_en     (in_en),
    .m_axis_ctl_pifo_rank      (rank),
    .m_axis_ctl_pifo_len       (len)
`ifdef ENQ_AGENT_STATS_EN
    ,
    .stat_sel                  (stat_sel),
    .stat_clr                  (stat_clr),
    .stat_enq_cnt              (stat_enq_cnt),
    .stat_drop_cnt             (stat_drop_cnt)
`endif
  );

  // phys/cpu: per-port dst bits; drop: tuser[32]; rk: tuser[79:64]
  function automatic logic [127:0] mk_tuser(input logic [3:0] phys, input logic [3:0] cpu,
                                            input logic drop, input logic [15:0] rk);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      t[24 + 2*i]     = phys[i];
      t[24 + 2*i + 1] = cpu[i];
    end
    t[32]      = drop;
    t[64 +: 16] = rk;
    return t;
  endfunction

  // Apply one cycle of input on the falling edge
  task automatic drive(input logic v, input logic [127:0] tu, input logic tl);
    @(negedge clk);
    tvalid = v;
    tuser  = tu;
    tlast  = tl;
  endtask

  task automatic test_reset;
    rst = 1'b1; tvalid = 0; tuser = '0; tlast = 0; baf = '0; pfull = '0;
`ifdef ENQ_AGENT_STATS_EN
    stat_sel = '0; stat_clr = 0;
`endif
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", tready); end
    checks++; if ({wr_en, in_en, rank, len} !== '0) begin errors++;
      $display("FAIL reset_outputs got wr=%b in=%b rank=%h len=%0d exp all 0", wr_en, in_en, rank, len); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b exp 1", tready); end
  endtask

  task automatic test_af_mask;
    drive(1, mk_tuser(4'b1001, 4'b0000, 0, 16'h0000), 0);
    baf = 5'b01110;
    #1;
    checks++; if (wr_en !== 5'b00001) begin errors++; $display("FAIL t1_wr_b0 got %b exp 00001", wr_en); end
    drive(1, '0, 1);
    #1;
    checks++; if (wr_en !== 5'b00001) begin errors++; $display("FAIL t1_wr_b1 got %b exp 00001", wr_en); end
    drive(0, '0, 0);
    baf = '0;
    #1;
    checks++; if (in_en !== 5'b00001) begin errors++; $display("FAIL t1_in_en got %b exp 00001", in_en); end
    checks++; if (len !== 12'd2) begin errors++; $display("FAIL t1_len got %0d exp 2", len); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b00000) begin errors++; $display("FAIL t1_pulse got %b exp 00000", in_en); end
  endtask

  task automatic test_multi_gap;
    drive(1, mk_tuser(4'b1110, 4'b0000, 0, 16'h00A5), 0);
    #1;
    checks++; if (wr_en !== 5'b01110) begin errors++; $display("FAIL t2_wr_b0 got %b exp 01110", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (wr_en !== 5'b00000) begin errors++; $display("FAIL t2_gap got %b exp 00000", wr_en); end
    drive(1, '0, 0);
    #1;
    checks++; if (wr_en !== 5'b01110) begin errors++; $display("FAIL t2_wr_b1 got %b exp 01110", wr_en); end
    drive(1, '0, 1);
    #1;
    checks++; if (wr_en !== 5'b01110) begin errors++; $display("FAIL t2_wr_b2 got %b exp 01110", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b01110) begin errors++; $display("FAIL t2_in_en got %b exp 01110", in_en); end
    checks++; if (rank !== 16'h00A5) begin errors++; $display("FAIL t2_rank got %h exp 00a5", rank); end
    checks++; if (len !== 12'd3) begin errors++; $display("FAIL t2_len got %0d exp 3", len); end
  endtask

  task automatic test_pifo_full_drop;
`ifdef ENQ_AGENT_STATS_EN
    @(negedge clk); stat_clr = 1;
    @(negedge clk); stat_clr = 0;
`endif
    pfull = 5'b01110;
    drive(1, mk_tuser(4'b1110, 4'b0000, 0, 16'h0001), 0);
    #1;
    checks++; if (wr_en !== 5'b00000) begin errors++; $display("FAIL t3_wr_b0 got %b exp 00000", wr_en); end
    drive(1, '0, 1);
    pfull = '0;
    #1;
    checks++; if (wr_en !== 5'b00000) begin errors++; $display("FAIL t3_wr_b1 got %b exp 00000", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b00000) begin errors++; $display("FAIL t3_in_en got %b exp 00000", in_en); end
`ifdef ENQ_AGENT_STATS_EN
    for (int q = 0; q < 5; q++) begin
      @(negedge clk); stat_sel = 3'(q);
      @(negedge clk); #1;
      checks++;
      if (stat_drop_cnt !== ((q >= 1 && q <= 3) ? 32'd1 : 32'd0)) begin errors++;
        $display("FAIL t3_dropcnt_q%0d got %0d", q, stat_drop_cnt); end
    end
`endif
  endtask

  task automatic test_cpu_drop_midpkt;
    drive(1, mk_tuser(4'b0000, 4'b0011, 0, 16'h0002), 1);
    #1;
    checks++; if (wr_en !== 5'b10000) begin errors++; $display("FAIL t4_cpu_wr got %b exp 10000", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b10000) begin errors++; $display("FAIL t4_cpu_in got %b exp 10000", in_en); end
    drive(1, mk_tuser(4'b0111, 4'b0000, 1, 16'h0003), 1);
    #1;
    checks++; if (wr_en !== 5'b00000) begin errors++; $display("FAIL t4_drop_wr got %b exp 00000", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b00000) begin errors++; $display("FAIL t4_drop_in got %b exp 00000", in_en); end
    drive(1, mk_tuser(4'b0011, 4'b0000, 0, 16'h0004), 0);
    #1;
    checks++; if (wr_en !== 5'b00011) begin errors++; $display("FAIL t4_mid_b0 got %b exp 00011", wr_en); end
    drive(1, mk_tuser(4'b1100, 4'b0000, 0, 16'h0000), 0);
    pfull = 5'b11111; baf = 5'b11111;
    #1;
    checks++; if (wr_en !== 5'b00011) begin errors++; $display("FAIL t4_mid_b1 got %b exp 00011", wr_en); end
    drive(1, '0, 1);
    pfull = '0; baf = '0;
    #1;
    checks++; if (wr_en !== 5'b00011) begin errors++; $display("FAIL t4_mid_b2 got %b exp 00011", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b00011) begin errors++; $display("FAIL t4_mid_in got %b exp 00011", in_en); end
    checks++; if (rank !== 16'h0004) begin errors++; $display("FAIL t4_mid_rank got %h exp 0004", rank); end
    checks++; if (len !== 12'd3) begin errors++; $display("FAIL t4_mid_len got %0d exp 3", len); end
  endtask

  task automatic test_back_to_back;
    drive(1, mk_tuser(4'b0001, 4'b0000, 0, 16'h0011), 1);
    drive(1, mk_tuser(4'b0100, 4'b0000, 0, 16'h0022), 1);
    #1;
    checks++; if (in_en !== 5'b00001) begin errors++; $display("FAIL t5_in_a got %b exp 00001", in_en); end
    checks++; if (rank !== 16'h0011 || len !== 12'd1) begin errors++;
      $display("FAIL t5_desc_a got rank=%h len=%0d exp 0011/1", rank, len); end
    checks++; if (wr_en !== 5'b00100) begin errors++; $display("FAIL t5_wr_b got %b exp 00100", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b00100) begin errors++; $display("FAIL t5_in_b got %b exp 00100", in_en); end
    checks++; if (rank !== 16'h0022 || len !== 12'd1) begin errors++;
      $display("FAIL t5_desc_b got rank=%h len=%0d exp 0022/1", rank, len); end
  endtask

  task automatic test_reset_midpkt;
    drive(1, mk_tuser(4'b0001, 4'b0000, 0, 16'h0033), 0);
    drive(1, '0, 0);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL t5_rst_tready got %b exp 0", tready); end
    checks++; if ({wr_en, in_en, rank, len} !== '0) begin errors++;
      $display("FAIL t5_rst_out got wr=%b in=%b rank=%h len=%0d exp all 0", wr_en, in_en, rank, len); end
    drive(0, '0, 0);
    rst = 1'b0;
    drive(1, mk_tuser(4'b1000, 4'b0000, 0, 16'h0044), 1);
    #1;
    checks++; if (wr_en !== 5'b01000) begin errors++; $display("FAIL t5_sop_wr got %b exp 01000", wr_en); end
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b01000 || len !== 12'd1) begin errors++;
      $display("FAIL t5_sop_desc got in=%b len=%0d exp 01000/1", in_en, len); end
  endtask

  task automatic test_len_sat;
    drive(1, mk_tuser(4'b0010, 4'b0000, 0, 16'h0055), 0);
    for (int i = 0; i < 4100; i++) drive(1, '0, 0);
    drive(1, '0, 1);
    drive(0, '0, 0);
    #1;
    checks++; if (in_en !== 5'b00010) begin errors++; $display("FAIL sat_in got %b exp 00010", in_en); end
    checks++; if (len !== 12'hFFF) begin errors++; $display("FAIL sat_len got %0d exp 4095", len); end
  endtask

  initial begin
    test_reset;
    test_af_mask;
    test_multi_gap;
    test_pifo_full_drop;
    test_cpu_drop_midpkt;
    test_back_to_back;
    test_reset_midpkt;
    test_len_sat;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
